// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller feeding a combinational 32-bit Alu.
// It accepts one decoded instruction, drives registered operands and alu_ctr,
// captures the Alu outputs one cycle later and holds them until the consumer
// accepts the response.
module alu_issue_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [2:0]        alu_ctr,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              branch_taken,
    output logic              illegal
);

    localparam logic [2:0] CtrAnd = 3'b000;
    localparam logic [2:0] CtrOr  = 3'b001;
    localparam logic [2:0] CtrXor = 3'b010;
    localparam logic [2:0] CtrNor = 3'b011;
    localparam logic [2:0] CtrLt  = 3'b100;
    localparam logic [2:0] CtrAdd = 3'b101;
    localparam logic [2:0] CtrSub = 3'b110;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] imm_zext, imm_sext;
    logic [DATA_W-1:0] dec_src1, dec_src2;
    logic [2:0]        dec_ctr;
    logic              dec_branch, dec_bne, dec_illegal;
    logic              is_branch_q, is_bne_q;
    logic              accept;

    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm16};
    assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StResp);
    assign accept    = in_valid && in_ready;

    // Decode opcode/funct into Alu control, operand selection and flags.
    always_comb begin
        dec_ctr     = CtrAnd;
        dec_src1    = rs_data;
        dec_src2    = rt_data;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100100: dec_ctr = CtrAnd;
                    6'b100101: dec_ctr = CtrOr;
                    6'b100110: dec_ctr = CtrXor;
                    6'b100111: dec_ctr = CtrNor;
                    6'b101010: dec_ctr = CtrLt;
                    6'b100000: dec_ctr = CtrAdd;
                    6'b100010: dec_ctr = CtrSub;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001100: begin dec_ctr = CtrAnd; dec_src2 = imm_zext; end
            6'b001101: begin dec_ctr = CtrOr;  dec_src2 = imm_zext; end
            6'b001110: begin dec_ctr = CtrXor; dec_src2 = imm_zext; end
            6'b001010: begin dec_ctr = CtrLt;  dec_src2 = imm_sext; end
            6'b001000: begin dec_ctr = CtrAdd; dec_src2 = imm_sext; end
            6'b000100: begin dec_ctr = CtrSub; dec_branch = 1'b1; end
            6'b000101: begin dec_ctr = CtrSub; dec_branch = 1'b1; dec_bne = 1'b1; end
            default:   dec_illegal = 1'b1;
        endcase
        // Illegal instructions present a quiet all-zero Alu request.
        if (dec_illegal) begin
            dec_ctr  = CtrAnd;
            dec_src1 = '0;
            dec_src2 = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on out_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: load operands on accept, capture Alu outputs in EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_ctr      <= CtrAnd;
            is_branch_q  <= 1'b0;
            is_bne_q     <= 1'b0;
            illegal      <= 1'b0;
            result       <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (accept) begin
                alu_src1    <= dec_src1;
                alu_src2    <= dec_src2;
                alu_ctr     <= dec_ctr;
                is_branch_q <= dec_branch;
                is_bne_q    <= dec_bne;
                illegal     <= dec_illegal;
            end
            if (state_q == StExec) begin
                result       <= (is_branch_q || illegal) ? '0 : alu_result;
                // bne inverts the equality test carried by zero_bit.
                branch_taken <= is_branch_q && (zero_bit ^ is_bne_q);
            end
        end
    end

endmodule
